// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared types and sizing helpers for the ping-pong LED frame store.
//   wstate_t  : write-side states (filling, frame complete, dropping input)
//   rstate_t  : read-side states  (idle, start pulse, streaming to drivers)
//   ch_bits   : bits held per strip  (LEDs * bits per LED)
//   frame_bits: bits in a full frame (channels * bits per strip)
//   ptr_w     : pointer width for a range of n entries, never below 1
// ---------------------------------------------------------------------------
package led_pkg;

  typedef enum logic [1:0] {
    W_FILL,
    W_FULL,
    W_DROP
  } wstate_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_ACTIVE
  } rstate_t;

  function automatic int ch_bits(input int leds, input int bits_per_led);
    return leds * bits_per_led;
  endfunction

  function automatic int frame_bits(input int channels, input int leds, input int bits_per_led);
    return channels * leds * bits_per_led;
  endfunction

  function automatic int ptr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_bank_ram.sv
// ---------------------------------------------------------------------------
// led_bank_ram
// Two-bank bit memory: 2 banks x NUM_CHANNELS strips x CH_BITS bits.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (read register only)
//   wr_en           : store wr_bit at (wr_bank, wr_ch, wr_addr)
//   rd_en           : update the registered read port from (rd_bank, rd_addr)
//   rd_data         : one bit per channel, held while rd_en is low
// ---------------------------------------------------------------------------
module led_bank_ram #(
  parameter int NUM_CHANNELS = 1,
  parameter int CH_BITS      = 4080,
  parameter int CW           = 1,
  parameter int BW           = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic                    wr_bank,
  input  logic [CW-1:0]           wr_ch,
  input  logic [BW-1:0]           wr_addr,
  input  logic                    wr_bit,
  input  logic                    rd_en,
  input  logic                    rd_bank,
  input  logic [BW-1:0]           rd_addr,
  output logic [NUM_CHANNELS-1:0] rd_data
);

  logic [CH_BITS-1:0]      mem [2][NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] rd_data_q, rd_data_d;

  // Bit-granular write port; the storage itself is never reset so it can map
  // onto plain RAM, only the read register below is.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_bank][wr_ch][wr_addr] <= wr_bit;
    end
  end

  // Every channel reads the same bit index from the same bank. Holding the
  // previous value when rd_en is low keeps the driver outputs stable between
  // frames.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        rd_data_d[c] = mem[rd_bank][CW'(c)][rd_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/led_frame_pingpong.sv
// ---------------------------------------------------------------------------
// led_frame_pingpong
// Double-buffered frame store between a serial pixel-bit stream and
// NUM_CHANNELS parallel LED strip drivers. One bank fills while the other is
// streamed; banks swap only when a complete frame waits and the reader is idle.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_valid, in_bit    : serial frame bits, channel 0 first, MSB first
//   frame_start         : resync, next accepted bit is frame bit 0
//   drv_start           : one-cycle pulse, a new bank is being presented
//   drv_read            : advance the shared read index
//   drv_data, drv_last  : current bit per channel, last-bit-of-strip flag
//   drv_done            : drivers finished the frame
//   overrun             : sticky, a frame was dropped or overwritten
//   frames_shown        : number of bank swaps, wrapping 16-bit counter
// ---------------------------------------------------------------------------
module led_frame_pingpong
  import led_pkg::*;
#(
  parameter int NUM_CHANNELS    = 1,
  parameter int NUM_LEDS        = 170,
  parameter int BITS_PER_LED    = 24,
  parameter int DROP_ON_OVERRUN = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic                    in_bit,
  input  logic                    frame_start,
  output logic                    drv_start,
  input  logic                    drv_read,
  output logic [NUM_CHANNELS-1:0] drv_data,
  output logic                    drv_last,
  input  logic                    drv_done,
  output logic                    overrun,
  output logic [15:0]             frames_shown
);

  localparam int CH_BITS = ch_bits(NUM_LEDS, BITS_PER_LED);
  localparam int CW      = ptr_w(NUM_CHANNELS);
  localparam int BW      = ptr_w(CH_BITS);
  localparam logic [CW-1:0] LAST_CH  = CW'(NUM_CHANNELS - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(CH_BITS - 1);

  wstate_t       wstate_q, wstate_d;
  rstate_t       rstate_q, rstate_d;
  logic [CW-1:0] wch_q, wch_d;
  logic [BW-1:0] wbit_q, wbit_d;
  logic [BW-1:0] ri_q, ri_d;
  logic          wbank_q, wbank_d;
  logic          rbank_q, rbank_d;
  logic          swap_seen_q, swap_seen_d;
  logic          drv_start_q, drv_start_d;
  logic          drv_last_q, drv_last_d;
  logic          overrun_q, overrun_d;
  logic [15:0]   frames_q, frames_d;

  logic          pending, swap, fill, wr_en, rd_en;
  logic [CW-1:0] cur_ch;
  logic [BW-1:0] cur_bit;

  // Next-state logic for both sides. The linear write pointer is kept as a
  // (channel, bit) pair so no division is needed to address the RAM. A frame
  // counts as pending while waiting in W_FULL, and also in W_DROP until the
  // swap that shows it has happened (swap_seen). In a swap cycle the input is
  // accepted as the first bits of the next frame in the freshly freed bank.
  always_comb begin
    wstate_d    = wstate_q;
    rstate_d    = rstate_q;
    wch_d       = wch_q;
    wbit_d      = wbit_q;
    ri_d        = ri_q;
    wbank_d     = wbank_q;
    rbank_d     = rbank_q;
    swap_seen_d = swap_seen_q;
    overrun_d   = overrun_q;
    frames_d    = frames_q;
    drv_last_d  = drv_last_q;
    fill        = 1'b0;
    wr_en       = 1'b0;
    cur_ch      = frame_start ? '0 : wch_q;
    cur_bit     = frame_start ? '0 : wbit_q;

    pending     = (wstate_q == W_FULL) || ((wstate_q == W_DROP) && !swap_seen_q);
    swap        = pending && (rstate_q == R_IDLE);
    drv_start_d = swap;

    if (swap) begin
      wbank_d  = ~wbank_q;
      rbank_d  = wbank_q;
      frames_d = frames_q + 16'd1;
    end

    case (wstate_q)
      W_FILL: fill = 1'b1;
      W_FULL: begin
        if (swap) begin
          wstate_d = W_FILL;
          fill     = 1'b1;
        end else if (in_valid || frame_start) begin
          overrun_d = 1'b1;
          if (DROP_ON_OVERRUN != 0) begin
            wstate_d    = W_DROP;
            swap_seen_d = 1'b0;
          end else begin
            wstate_d = W_FILL;
            fill     = 1'b1;
          end
        end
      end
      W_DROP: begin
        if (swap) begin
          swap_seen_d = 1'b1;
        end else if (swap_seen_q && frame_start) begin
          wstate_d = W_FILL;
          fill     = 1'b1;
        end
      end
      default: wstate_d = W_FILL;
    endcase

    if (fill) begin
      wch_d  = cur_ch;
      wbit_d = cur_bit;
      if (in_valid) begin
        wr_en = 1'b1;
        if (cur_bit == LAST_BIT) begin
          wbit_d = '0;
          if (cur_ch == LAST_CH) begin
            wch_d    = '0;
            wstate_d = W_FULL;
          end else begin
            wch_d = cur_ch + 1'b1;
          end
        end else begin
          wbit_d = cur_bit + 1'b1;
        end
      end
    end

    case (rstate_q)
      R_IDLE: begin
        if (swap) begin
          rstate_d = R_START;
          ri_d     = '0;
        end
      end
      R_START: rstate_d = R_ACTIVE;
      R_ACTIVE: begin
        if (drv_done) begin
          rstate_d = R_IDLE;
        end else if (drv_read && (ri_q != LAST_BIT)) begin
          ri_d = ri_q + 1'b1;
        end
      end
      default: rstate_d = R_IDLE;
    endcase

    // Reading the next index keeps drv_data aligned with ri; going idle
    // freezes the last presented bit.
    rd_en = (rstate_d != R_IDLE);
    if (rd_en) begin
      drv_last_d = (ri_d == LAST_BIT);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wstate_q    <= W_FILL;
      rstate_q    <= R_IDLE;
      wch_q       <= '0;
      wbit_q      <= '0;
      ri_q        <= '0;
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
      swap_seen_q <= 1'b0;
      drv_start_q <= 1'b0;
      drv_last_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frames_q    <= 16'd0;
    end else begin
      wstate_q    <= wstate_d;
      rstate_q    <= rstate_d;
      wch_q       <= wch_d;
      wbit_q      <= wbit_d;
      ri_q        <= ri_d;
      wbank_q     <= wbank_d;
      rbank_q     <= rbank_d;
      swap_seen_q <= swap_seen_d;
      drv_start_q <= drv_start_d;
      drv_last_q  <= drv_last_d;
      overrun_q   <= overrun_d;
      frames_q    <= frames_d;
    end
  end

  led_bank_ram #(
    .NUM_CHANNELS(NUM_CHANNELS),
    .CH_BITS     (CH_BITS),
    .CW          (CW),
    .BW          (BW)
  ) u_ram (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_bank(wbank_d),
    .wr_ch  (cur_ch),
    .wr_addr(cur_bit),
    .wr_bit (in_bit),
    .rd_en  (rd_en),
    .rd_bank(rbank_d),
    .rd_addr(ri_d),
    .rd_data(drv_data)
  );

  assign drv_start    = drv_start_q;
  assign drv_last     = drv_last_q;
  assign overrun      = overrun_q;
  assign frames_shown = frames_q;

endmodule

// File: tb/tb_led_frame_pingpong.sv
// ---------------------------------------------------------------------------
// tb_led_frame_pingpong
// Bench for led_frame_pingpong with 2 strips of 2 RGB LEDs (48 bits/strip,
// 96 bits/frame) and the drop-on-overrun policy. A frame-level model built on
// a bit queue and whole-frame arrays predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_led_frame_pingpong;

  localparam int NCH  = 2;
  localparam int NLED = 2;
  localparam int BPL  = 24;
  localparam int DROP = 1;
  localparam int CHB  = NLED * BPL;
  localparam int FRM  = NCH * CHB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_bit = 1'b0;
  logic frame_start = 1'b0;
  logic drv_read = 1'b0;
  logic drv_done = 1'b0;
  logic drv_start, drv_last, overrun;
  logic [NCH-1:0] drv_data;
  logic [15:0] frames_shown;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  led_frame_pingpong #(
    .NUM_CHANNELS   (NCH),
    .NUM_LEDS       (NLED),
    .BITS_PER_LED   (BPL),
    .DROP_ON_OVERRUN(DROP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .frame_start (frame_start),
    .drv_start   (drv_start),
    .drv_read    (drv_read),
    .drv_data    (drv_data),
    .drv_last    (drv_last),
    .drv_done    (drv_done),
    .overrun     (overrun),
    .frames_shown(frames_shown)
  );

  // Model state: bits collected so far, a completed frame waiting for display,
  // the frame on display and its read index.
  bit          partial[$];
  bit          pend[FRM];
  bit          show[FRM];
  bit          have_pending, drop_mode, busy, fresh, m_overrun, exp_start, exp_last;
  bit          model_live = 1'b0;
  int          idx;
  logic [15:0] shown;
  logic [NCH-1:0] exp_data;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Frame-level reference. A waiting frame is shown as soon as the display is
  // free; while in drop mode, input is ignored until the waiting frame has
  // been taken and a frame_start arrives.
  always @(posedge clk) begin
    bit pre_pending, do_swap, accept;
    model_live = 1'b1;
    if (reset) begin
      partial.delete();
      have_pending = 0; drop_mode = 0; busy = 0; fresh = 0; m_overrun = 0;
      exp_start = 0; exp_last = 0; idx = 0; shown = 16'd0; exp_data = '0;
    end else begin
      pre_pending = have_pending;
      do_swap = have_pending && !busy;
      exp_start = do_swap;
      if (do_swap) begin
        show = pend; busy = 1; fresh = 1; idx = 0; shown = shown + 16'd1; have_pending = 0;
      end else if (busy) begin
        if (fresh) fresh = 0;
        else if (drv_done) busy = 0;
        else if (drv_read && idx < CHB - 1) idx++;
      end
      accept = 0;
      if (drop_mode) begin
        if (!pre_pending && frame_start) begin drop_mode = 0; accept = 1; end
      end else if (pre_pending && !do_swap) begin
        if (in_valid || frame_start) begin
          m_overrun = 1;
          if (DROP != 0) drop_mode = 1;
          else begin have_pending = 0; accept = 1; end
        end
      end else begin
        accept = 1;
      end
      if (accept) begin
        if (frame_start) partial.delete();
        if (in_valid) partial.push_back(in_bit);
        if (partial.size() == FRM) begin
          for (int i = 0; i < FRM; i++) pend[i] = partial[i];
          partial.delete();
          have_pending = 1;
        end
      end
      if (busy) begin
        for (int c = 0; c < NCH; c++) exp_data[c] = show[c * CHB + idx];
        exp_last = (idx == CHB - 1);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_live) begin
      checkOutput("drv_start", 32'(drv_start), 32'(exp_start));
      checkOutput("drv_data", 32'(drv_data), 32'(exp_data));
      checkOutput("drv_last", 32'(drv_last), 32'(exp_last));
      checkOutput("overrun", 32'(overrun), 32'(m_overrun));
      checkOutput("frames_shown", 32'(frames_shown), 32'(shown));
    end
  end

  task automatic applyStimulus(input logic v, input logic b, input logic fs, input logic rd, input logic dn);
    in_valid = v; in_bit = b; frame_start = fs; drv_read = rd; drv_done = dn;
    @(negedge clk);
  endtask

  // alt: bits alternate 1,0,1,... starting at bit 0; otherwise random bits.
  task automatic sendFrame(input int n, input bit alt, input bit fs_first, input bit rd_rand, input bit done_last);
    logic b;
    for (int i = 0; i < n; i++) begin
      b = alt ? (i % 2 == 0) : 1'($urandom_range(0, 1));
      applyStimulus(1'b1, b, fs_first && (i == 0),
                    rd_rand ? 1'($urandom_range(0, 1)) : 1'b0, done_last && (i == n - 1));
    end
  endtask

  task automatic idleCycles(input int n, input bit rd_rand);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, rd_rand ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0);
    end
  endtask

  initial begin
    $display("[TB] start");
    reset = 1'b1;
    idleCycles(3, 0);
    checkOutput("reset_start", 32'(drv_start), 0);
    checkOutput("reset_data", 32'(drv_data), 0);
    checkOutput("reset_last", 32'(drv_last), 0);
    checkOutput("reset_overrun", 32'(overrun), 0);
    checkOutput("reset_frames", 32'(frames_shown), 0);
    reset = 1'b0;

    // Frame 1: alternating bits, start pulse two cycles after the last bit.
    sendFrame(FRM, 1, 0, 0, 0);
    checkOutput("f1_start_early", 32'(drv_start), 0);
    idleCycles(1, 0);
    checkOutput("f1_start", 32'(drv_start), 1);
    checkOutput("f1_frames", 32'(frames_shown), 1);
    checkOutput("f1_bit0", 32'(drv_data), 3);
    idleCycles(1, 0);
    checkOutput("f1_start_once", 32'(drv_start), 0);
    for (int i = 0; i < CHB - 1; i++) applyStimulus(0, 0, 0, 1, 0);
    checkOutput("f1_last47", 32'(drv_last), 1);
    checkOutput("f1_bit47", 32'(drv_data), 0);

    // Frame 2 written while frame 1 is displayed, swapped in on drv_done.
    sendFrame(FRM, 0, 0, 1, 0);
    idleCycles(3, 1);
    checkOutput("f2_waiting", 32'(frames_shown), 1);
    checkOutput("f2_no_overrun", 32'(overrun), 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("f2_start_early", 32'(drv_start), 0);
    idleCycles(1, 0);
    checkOutput("f2_start", 32'(drv_start), 1);
    checkOutput("f2_frames", 32'(frames_shown), 2);

    // Two more frames without drv_done: the second is dropped.
    idleCycles(2, 1);
    sendFrame(FRM, 0, 0, 1, 0);
    checkOutput("drop_pre_overrun", 32'(overrun), 0);
    sendFrame(FRM, 0, 0, 1, 0);
    checkOutput("drop_overrun", 32'(overrun), 1);
    checkOutput("drop_frames", 32'(frames_shown), 2);
    applyStimulus(0, 0, 0, 0, 1);
    idleCycles(1, 0);
    checkOutput("drop_shown_start", 32'(drv_start), 1);
    checkOutput("drop_shown_frames", 32'(frames_shown), 3);
    idleCycles(60, 1);
    sendFrame(FRM, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
    idleCycles(1, 0);
    checkOutput("resync_start", 32'(drv_start), 1);
    checkOutput("resync_frames", 32'(frames_shown), 4);

    // Partial frame discarded by frame_start is not an overrun.
    reset = 1'b1;
    idleCycles(2, 0);
    reset = 1'b0;
    checkOutput("rst2_overrun", 32'(overrun), 0);
    sendFrame(30, 0, 0, 0, 0);
    sendFrame(FRM, 1, 1, 0, 0);
    idleCycles(1, 0);
    checkOutput("fs_start", 32'(drv_start), 1);
    checkOutput("fs_bit0", 32'(drv_data), 3);
    checkOutput("fs_overrun", 32'(overrun), 0);
    idleCycles(1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("fs_bit1", 32'(drv_data), 0);

    // drv_done on the same cycle as the last write bit.
    sendFrame(FRM, 0, 0, 1, 1);
    checkOutput("same_c1", 32'(drv_start), 0);
    idleCycles(1, 0);
    checkOutput("same_c2", 32'(drv_start), 1);
    idleCycles(1, 0);
    checkOutput("same_c3", 32'(drv_start), 0);
    applyStimulus(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 0);

    // Reset in the middle of a frame.
    sendFrame(50, 0, 0, 0, 0);
    reset = 1'b1;
    idleCycles(2, 0);
    reset = 1'b0;
    checkOutput("midrst_data", 32'(drv_data), 0);
    checkOutput("midrst_frames", 32'(frames_shown), 0);
    checkOutput("midrst_last", 32'(drv_last), 0);
    sendFrame(FRM, 1, 0, 0, 0);
    idleCycles(1, 0);
    checkOutput("midrst_start", 32'(drv_start), 1);
    checkOutput("midrst_bit0", 32'(drv_data), 3);
    checkOutput("midrst_frames1", 32'(frames_shown), 1);

    // Random soak.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 119) == 0);
    end
    idleCycles(2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
